key_debounce: RTL and testbench
===============================

# key_debounce

Multi-channel push-button conditioner sitting directly upstream of the LED pattern controller. Synchronises raw active-low button pins, rejects bounce with a per-channel stable-time window, and delivers clean debounced levels plus single-cycle press/release strobes. It also delivers a registered key code for the lowest-index key pressed. The LED controller consumes `key_press`/`key_code` instead of doing its own edge detection and delay counting.

## Interface

- `N_BTN`, 3: number of button channels (1..8).
- `DEBOUNCE_CYCLES`, 1000000: stable-sample window in clk cycles (20 ms at 50 MHz); legal range ≥ 2.
- `CW`, `$clog2(DEBOUNCE_CYCLES)`: counter width (derived; not overridden).

- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `button_io`  input  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk.
- `key_level`  output  N_BTN  debounced state, 1 = pressed.
- `key_press`  output  N_BTN  one-cycle strobe per channel on debounced press.
- `key_release`  output  N_BTN  one-cycle strobe per channel on debounced release.
- `key_valid`  output  1  one-cycle strobe: at least one press was reported in the previous cycle.
- `key_code`  output  3  index of the lowest-numbered channel in that press set; holds the value between strobes.

## Operation

- Per channel, a 2-FF synchroniser: `s1 <= button_io[i]`, `s2 <= s1`. Both reset to 1 (released). The FSM sees only `s2`.
- Per channel, an independent 4-state FSM with a private CW-bit counter:
  - IDLE (level 0): if `s2==0`, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT (level 0): if `s2==1`, return to IDLE with no strobe. Else if `cnt==DEBOUNCE_CYCLES-1`, go to PRESSED, set `key_level[i]=1`, pulse `key_press[i]`. Else increment cnt.
  - PRESSED (level 1): if `s2==1`, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT (level 1): if `s2==0`, return to PRESSED with no strobe. Else if `cnt==DEBOUNCE_CYCLES-1`, go to IDLE, clear level, pulse `key_release[i]`. Else increment cnt.
- The counter never wraps. Any opposite sample restarts the window from 0 on the next entry.
- Key code: each cycle where `key_press != 0`, register `key_code` = lowest set index and assert `key_valid` on the next cycle. Higher simultaneous presses still appear on `key_press` but are not encoded.
- All outputs are registered; there are no combinational paths from `button_io`.

## Timing

- Reset values: every state = IDLE, cnt = 0, s1/s2 = 1; `key_level`, `key_press`, `key_release`, `key_valid` = 0; `key_code` = 0.
- Reset asserted mid-window aborts the window; no strobe is emitted, including on reset release.
- A button held through reset release is treated as a new press: the strobe follows the full latency below.
- Press latency: first clk edge sampling `button_io[i]=0` = edge 0. `s2` goes low at edge 1, PRESS_WAIT is entered at edge 2, and `key_press[i]`/`key_level[i]` rise at edge `DEBOUNCE_CYCLES+2`. This requires no high sample on `s2` in between.
- Release latency: symmetric, with `key_release[i]` at edge `DEBOUNCE_CYCLES+2` after the first high sample.
- `key_valid`/`key_code` update one edge after the corresponding `key_press` (edge `DEBOUNCE_CYCLES+3`).
- Strobe width is exactly 1 cycle. There is at most one press and one release strobe per debounced transition, and press/release strictly alternate per channel.
- Channels are fully independent; simultaneous events on different channels never block each other.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=8`, N_BTN=3.

- Clean press: `button_io[0]` low for 20 cycles from edge 0 -> `key_press[0]` high only at edge 10, `key_level[0]`=1 from edge 10, `key_valid`=1 with `key_code`=0 at edge 11.
- Bounce: `button_io[1]` pattern low 5 / high 1 / low 5 / high 1, then low 30 -> exactly one `key_press[1]`, 10 edges after the start of the final low run; no strobes earlier.
- Glitch reject: `button_io[2]` low for 7 cycles, then high -> no strobes, and `key_level` stays 0. A following release of a held key bouncing 1 high cycle -> no `key_release`.
- Release: after a debounced press of channel 0, drive the pin high for 20 cycles -> `key_release[0]` one cycle at edge 10 after the rising sample, and `key_level[0]` drops on the same edge.
- Simultaneous: channels 1 and 2 go low on the same edge -> `key_press`=3'b110 in one cycle, then `key_valid`=1 with `key_code`=1.
- Reset mid-window: channel 0 low, `reset` pulsed at edge 5, pin kept low -> all outputs 0 during reset, and no strobe at the old edge 10. `key_press[0]` occurs 10 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-channel active-low button debouncer with press/release strobes and key code
module key_debounce #(
  parameter  int N_BTN           = 3,
  parameter  int DEBOUNCE_CYCLES = 1000000,
  localparam int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] button_io,
  output logic [N_BTN-1:0] key_level,
  output logic [N_BTN-1:0] key_press,
  output logic [N_BTN-1:0] key_release,
  output logic             key_valid,
  output logic [2:0]       key_code
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [2:0]       w_low_idx;
  logic             r_valid;
  logic [2:0]       r_code;

  // Synchronisers idle at 1 so a reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= button_io;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;
    logic          r_level_ch;
    logic          r_press_ch;
    logic          r_release_ch;

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_s2[g]) begin
            w_state_nxt = ST_PRESS_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (r_s2[g]) begin
            w_state_nxt = ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_PRESSED;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (r_s2[g]) begin
            w_state_nxt = ST_RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!r_s2[g]) begin
            w_state_nxt = ST_PRESSED;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        r_level_ch   <= 1'b0;
        r_press_ch   <= 1'b0;
        r_release_ch <= 1'b0;
      end else begin
        r_state      <= w_state_nxt;
        r_cnt        <= w_cnt_nxt;
        r_level_ch   <= (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
        r_press_ch   <= w_press_nxt;
        r_release_ch <= w_release_nxt;
      end
    end

    assign w_level[g]   = r_level_ch;
    assign w_press[g]   = r_press_ch;
    assign w_release[g] = r_release_ch;
  end

  // Lowest set index wins when several channels press together.
  always_comb begin
    w_low_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_press[i]) w_low_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      r_valid <= |w_press;
      if (|w_press) r_code <= w_low_idx;
    end
  end

  assign key_level   = w_level;
  assign key_press   = w_press;
  assign key_release = w_release;
  assign key_valid   = r_valid;
  assign key_code    = r_code;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce with directed table, corner sequences and random run
module tb_key_debounce;

  localparam int NB = 3;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] button_io;
  logic [NB-1:0] key_level;
  logic [NB-1:0] key_press;
  logic [NB-1:0] key_release;
  logic          key_valid;
  logic [2:0]    key_code;

  key_debounce #(.N_BTN(NB), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .button_io  (button_io),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ecnt   = 0;

  // Reference: a debounced level flips once DC+1 consecutive synchronised samples disagree with it.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_level, m_press, m_release, m_prev_press;
  logic          m_valid;
  logic [2:0]    m_code;
  int            m_run[NB];

  int press_cnt[NB];
  int rel_cnt[NB];
  int last_press_edge[NB];
  logic [NB-1:0] pins_cur;

  typedef struct {
    logic [2:0] pins;
    int         n;
    logic [2:0] press;
    logic [2:0] level;
    logic [2:0] rel;
    logic       valid;
    logic [2:0] code;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back('1);
    hist.push_back('1);
    m_level = '0; m_press = '0; m_release = '0; m_prev_press = '0;
    m_valid = 1'b0; m_code = '0;
    for (int c = 0; c < NB; c++) m_run[c] = 0;
  endtask

  task automatic model_step(input logic [NB-1:0] pins);
    logic [NB-1:0] v;
    v = hist.pop_front();
    hist.push_back(pins);
    m_valid = (m_prev_press != 0);
    if (m_prev_press != 0) begin
      for (int c = NB - 1; c >= 0; c--) if (m_prev_press[c]) m_code = 3'(c);
    end
    m_press = '0;
    m_release = '0;
    for (int c = 0; c < NB; c++) begin
      if (!v[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DC + 1) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_press[c] = 1'b1;
          else m_release[c] = 1'b1;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_prev_press = m_press;
  endtask

  task automatic tick(input logic [NB-1:0] pins);
    button_io = pins;
    @(posedge clk);
    #1;
    ecnt++;
    model_step(pins);
    check("model", {19'd0, key_level, key_press, key_release, key_valid, key_code},
          {19'd0, m_level, m_press, m_release, m_valid, m_code});
    for (int c = 0; c < NB; c++) begin
      if (key_press[c]) begin
        press_cnt[c]++;
        last_press_edge[c] = ecnt;
      end
      if (key_release[c]) rel_cnt[c]++;
    end
  endtask

  task automatic hold(input int ch, input logic val, input int n);
    pins_cur[ch] = val;
    repeat (n) tick(pins_cur);
  endtask

  task automatic clear_tally();
    for (int c = 0; c < NB; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c] = 0;
      last_press_edge[c] = -1;
    end
  endtask

  initial begin
    int e0;
    int hold_left[NB];

    reset = 1'b1;
    button_io = '1;
    pins_cur = '1;
    model_reset();
    clear_tally();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {24'd0, key_level, key_press, key_release, key_valid, key_code}, 32'd0);
    reset = 1'b0;
    repeat (3) tick(3'b111);

    // Clean press/release on ch0, then simultaneous ch1+ch2.
    tbl[0]  = '{3'b110, 10, 3'b000, 3'b000, 3'b000, 1'b0, 3'd0};
    tbl[1]  = '{3'b110,  1, 3'b001, 3'b001, 3'b000, 1'b0, 3'd0};
    tbl[2]  = '{3'b110,  1, 3'b000, 3'b001, 3'b000, 1'b1, 3'd0};
    tbl[3]  = '{3'b110,  8, 3'b000, 3'b001, 3'b000, 1'b0, 3'd0};
    tbl[4]  = '{3'b111, 10, 3'b000, 3'b001, 3'b000, 1'b0, 3'd0};
    tbl[5]  = '{3'b111,  1, 3'b000, 3'b000, 3'b001, 1'b0, 3'd0};
    tbl[6]  = '{3'b111,  5, 3'b000, 3'b000, 3'b000, 1'b0, 3'd0};
    tbl[7]  = '{3'b001, 10, 3'b000, 3'b000, 3'b000, 1'b0, 3'd0};
    tbl[8]  = '{3'b001,  1, 3'b110, 3'b110, 3'b000, 1'b0, 3'd0};
    tbl[9]  = '{3'b001,  1, 3'b000, 3'b110, 3'b000, 1'b1, 3'd1};
    tbl[10] = '{3'b111, 10, 3'b000, 3'b110, 3'b000, 1'b0, 3'd1};
    tbl[11] = '{3'b111,  1, 3'b000, 3'b000, 3'b110, 1'b0, 3'd1};
    tbl[12] = '{3'b111,  3, 3'b000, 3'b000, 3'b000, 1'b0, 3'd1};
    for (int r = 0; r < 13; r++) begin
      repeat (tbl[r].n) tick(tbl[r].pins);
      check($sformatf("vec%0d", r), {19'd0, key_level, key_press, key_release, key_valid, key_code},
            {19'd0, tbl[r].level, tbl[r].press, tbl[r].rel, tbl[r].valid, tbl[r].code});
    end
    pins_cur = '1;

    // Bounce on ch1: one press, 10 edges after the final low run begins.
    clear_tally();
    hold(1, 1'b0, 5); hold(1, 1'b1, 1); hold(1, 1'b0, 5); hold(1, 1'b1, 1);
    e0 = ecnt + 1;
    hold(1, 1'b0, 30);
    check("bounce_press_cnt", press_cnt[1], 1);
    check("bounce_press_edge", last_press_edge[1], e0 + 10);
    hold(1, 1'b1, 12);

    // Glitch of DC-1 cycles on ch2 is rejected.
    clear_tally();
    hold(2, 1'b0, 7);
    hold(2, 1'b1, 12);
    check("glitch_press_cnt", press_cnt[2] + rel_cnt[2], 0);
    check("glitch_level", key_level, 3'b000);

    // One-cycle release bounce on a held key is rejected.
    hold(0, 1'b0, 12);
    clear_tally();
    hold(0, 1'b1, 1);
    hold(0, 1'b0, 12);
    check("held_bounce_rel", rel_cnt[0], 0);
    hold(0, 1'b1, 12);
    check("held_real_rel", rel_cnt[0], 1);

    // Reset mid-window on ch0 with the pin held low.
    clear_tally();
    hold(0, 1'b0, 5);
    reset = 1'b1;
    #1;
    check("rst_async", {24'd0, key_level, key_press, key_release, key_valid, key_code}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    ecnt++;
    check("rst_hold", {24'd0, key_level, key_press, key_release, key_valid, key_code}, 32'd0);
    reset = 1'b0;
    e0 = ecnt + 1;
    hold(0, 1'b0, 14);
    check("rst_press_cnt", press_cnt[0], 1);
    check("rst_press_edge", last_press_edge[0], e0 + 10);
    hold(0, 1'b1, 12);

    // Random held levels per channel against the reference.
    for (int c = 0; c < NB; c++) hold_left[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold_left[c] == 0) begin
          pins_cur[c] = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 14);
        end else begin
          hold_left[c]--;
        end
      end
      tick(pins_cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
